spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: ADDR_SIZE, default 8, RAM address/data width; frame length F = ADDR_SIZE+2 bits.
REQ-002 Port: clk  in  1  SPI serial clock; all logic is on its rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: SS_n  in  1  slave select, active low; low = frame in progress.
REQ-005 Port: MOSI  in  1  serial data in, MSB first, sampled on rising clk.
REQ-006 Port: MISO  out  1  serial read data out, MSB first; 0 when not transmitting.
REQ-007 Port: rx_data  out  ADDR_SIZE+2  received frame to RAM: [F-1:F-2] command, [ADDR_SIZE-1:0] payload.
REQ-008 Port: rx_valid  out  1  one-cycle strobe, rx_data valid.
REQ-009 Port: tx_data  in  ADDR_SIZE  read data from RAM.
REQ-010 Port: tx_valid  in  1  tx_data valid, level, from RAM.

Function
REQ-011 States SHALL be exactly IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, in a registered state machine.
REQ-012 IDLE: SS_n=1 -> stay; SS_n=0 -> CHK_CMD.
REQ-013 CHK_CMD: samples the first frame bit (rx bit F-1); SS_n=1 -> IDLE; MOSI=0 -> WRITE; MOSI=1 and rd_addr_flag=0 -> READ_ADD; MOSI=1 and rd_addr_flag=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA: shift MOSI into bits F-2..0 on the next F-1 rising edges, counted by an internal bit counter.
REQ-015 On the edge sampling bit 0, rx_data SHALL load the full F-bit word and rx_valid SHALL go 1 for exactly one cycle.
REQ-016 rx_data SHALL hold its value between strobes; the shift register SHALL NOT drive rx_data directly.
REQ-017 WRITE and READ_ADD: after the frame completes, stay in that state, no further shifting or strobes, until SS_n=1.
REQ-018 rd_addr_flag: reset 0; set to 1 when a READ_ADD frame completes; cleared to 0 when a READ_DATA transmission completes.
REQ-019 READ_DATA: after rx_valid strobe, the first edge with tx_valid=1 latches tx_data and drives MISO=tx_data[ADDR_SIZE-1]; the next ADDR_SIZE-1 edges drive the remaining bits MSB to LSB; the following edge drives MISO=0.
REQ-020 Each READ_DATA frame SHALL transmit exactly once; tx_valid staying high after completion SHALL be ignored.
REQ-021 tx_valid=1 in any other state, or in READ_DATA before the rx_valid strobe, SHALL be ignored.
REQ-022 SS_n=1 in any non-IDLE state: next state IDLE, bit counter and transmit logic cleared, MISO=0, no rx_valid for the incomplete frame, rd_addr_flag unchanged.
REQ-023 SS_n=1 on the edge sampling bit 0: the frame is aborted, with no strobe.
REQ-024 A READ_DATA transmission aborted by SS_n SHALL leave rd_addr_flag at 1.
REQ-025 Back-to-back frames SHALL require SS_n=1 for at least one cycle (return through IDLE).

Reset
REQ-026 rst=1 on a rising edge: state IDLE, rx_data 0, rx_valid 0, MISO 0, rd_addr_flag 0, counter 0, transmit logic idle; overrides all other inputs, including mid-frame.

Verification
REQ-027 Write address (ADDR_SIZE=8): SS_n low, MOSI 00_0011_1100 -> rx_data=0x03C, rx_valid high one cycle, 11 edges after SS_n low sampled; MISO 0 throughout.
REQ-028 Write data: frame 01_1010_0101 -> rx_data=0x1A5, single rx_valid, state WRITE held until SS_n high.
REQ-029 Read sequence: frame 10_0011_1100 -> rx_data=0x23C, flag=1; next frame 11_0000_0000 -> READ_DATA, rx_data=0x300; tx_valid=1, tx_data=0xA5 -> MISO 1,0,1,0,0,1,0,1 then 0; flag=0; tx_valid held high causes no second burst.
REQ-030 Read-data without address: flag=0, frame 11_0101_0101 -> READ_ADD taken, rx_data=0x355, flag=1.
REQ-031 Abort: SS_n high after 5 bits of a WRITE frame -> IDLE, no rx_valid, rx_data unchanged; next full frame is received correctly.
REQ-032 Reset mid-transmit: rst=1 during MISO bit 3 of a READ_DATA burst -> all outputs 0, flag=0, next MOSI=1 frame enters READ_ADD.

Source files
------------

// File: rtl/spi_slave_if.sv
// spi_slave_if: serial pins plus the RAM-side frame/read-data handshake of the SPI slave.
`default_nettype none

interface spi_slave_if #(
  parameter int ADDR_SIZE = 8
);
  logic                   SS_n;
  logic                   MOSI;
  logic                   MISO;
  logic [ADDR_SIZE+1:0]   rx_data;
  logic                   rx_valid;
  logic [ADDR_SIZE-1:0]   tx_data;
  logic                   tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

`default_nettype wire

// File: rtl/spi_slave.sv
// ----------------------------------------------------------------------------
// spi_slave: SPI slave framing (write / read-address / read-data) for a RAM.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_slave #(
  parameter int ADDR_SIZE = 8
) (
  input  wire logic   clk,
  input  wire logic   rst,
  spi_slave_if.slave  bus
);

  localparam int F       = ADDR_SIZE + 2;
  localparam int CNT_W   = $clog2(F);
  localparam int TX_CW   = $clog2(ADDR_SIZE) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(F - 2);
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(F - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [F-2:0]           shift_q, shift_d;
  logic [F-1:0]           rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   miso_q, miso_d;
  logic                   rd_addr_flag_q, rd_addr_flag_d;
  logic                   tx_busy_q, tx_busy_d;
  logic                   tx_done_q, tx_done_d;
  logic [ADDR_SIZE-1:0]   tx_shift_q, tx_shift_d;
  logic [TX_CW-1:0]       tx_cnt_q, tx_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      miso_q         <= 1'b0;
      rd_addr_flag_q <= 1'b0;
      tx_busy_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      tx_shift_q     <= '0;
      tx_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      miso_q         <= miso_d;
      rd_addr_flag_q <= rd_addr_flag_d;
      tx_busy_q      <= tx_busy_d;
      tx_done_q      <= tx_done_d;
      tx_shift_q     <= tx_shift_d;
      tx_cnt_q       <= tx_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    miso_d         = 1'b0;
    rd_addr_flag_d = rd_addr_flag_q;
    tx_busy_d      = tx_busy_q;
    tx_done_d      = tx_done_q;
    tx_shift_d     = tx_shift_q;
    tx_cnt_d       = tx_cnt_q;

    // Deselect aborts any frame in flight; the read-address flag survives.
    if (state_q != IDLE && bus.SS_n) begin
      state_d    = IDLE;
      cnt_d      = '0;
      shift_d    = '0;
      tx_busy_d  = 1'b0;
      tx_done_d  = 1'b0;
      tx_shift_d = '0;
      tx_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d      = '0;
          shift_d    = '0;
          tx_busy_d  = 1'b0;
          tx_done_d  = 1'b0;
          tx_shift_d = '0;
          tx_cnt_d   = '0;
          if (!bus.SS_n) state_d = CHK_CMD;
        end

        CHK_CMD: begin
          shift_d = {shift_q[F-3:0], bus.MOSI};
          cnt_d   = '0;
          if (!bus.MOSI)           state_d = WRITE;
          else if (rd_addr_flag_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (cnt_q != DONE_CNT) begin
            shift_d = {shift_q[F-3:0], bus.MOSI};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              rx_data_d  = {shift_q, bus.MOSI};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) rd_addr_flag_d = 1'b1;
            end
          end else if (state_q == READ_DATA) begin
            // Frame received: one read burst per frame, MSB first.
            if (tx_busy_q) begin
              if (tx_cnt_q != '0) begin
                miso_d     = tx_shift_q[ADDR_SIZE-1];
                tx_shift_d = tx_shift_q << 1;
                tx_cnt_d   = tx_cnt_q - TX_CW'(1);
              end else begin
                tx_busy_d      = 1'b0;
                tx_done_d      = 1'b1;
                rd_addr_flag_d = 1'b0;
              end
            end else if (!tx_done_q && bus.tx_valid) begin
              miso_d     = bus.tx_data[ADDR_SIZE-1];
              tx_shift_d = bus.tx_data << 1;
              tx_cnt_d   = TX_CW'(ADDR_SIZE - 1);
              tx_busy_d  = 1'b1;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

`default_nettype wire
